result_writeback: RTL and testbench

- Downstream of the PE scheduler.
- Captures each completed output row-pair (two PE results for one output row, two weight columns) and queues the two words in a small FIFO.
- Drains the FIFO one word per cycle into the output-matrix SRAM write port at address {row, col}.
- Tracks completion of the full output matrix and flags dropped or illegal results.

---
 rtl/result_writeback.sv | 173 +++++++++++++++++
 tb/tb_result_writeback.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback.sv
// result_writeback
//   Collects completed output row-pairs from the PE scheduler, queues both
//   result words in a small FIFO and drains them one word per cycle into the
//   output-matrix SRAM write port at address {row, col}. Counts written words
//   to flag completion of the full output matrix, and flags captures that
//   were dropped (no room) or illegal (row out of range).
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   i_valid             scheduler result-valid level; its rising edge captures
//   i_result_1/2        PE1 / PE2 result words
//   i_row_idx           output row shared by both results
//   i_col_idx_1/2       output columns of result 1 / result 2
//   i_clear             synchronous clear of queue, write counter and flags
//   i_mem_ready         SRAM accepts the presented write this cycle
//   o_mem_wen           write request (queue not empty)
//   o_mem_addr          {row, col} of the head entry
//   o_mem_data          result word of the head entry
//   o_fifo_cnt          current queue occupancy
//   o_overflow          sticky: a capture was dropped for lack of space
//   o_range_err         sticky: a capture carried row >= OUT_ROWS
//   o_done              sticky: all OUT_ROWS*OUT_COLS words written
module result_writeback #(
   parameter int DATA_BITS     = 16,
   parameter int ROW_BITS      = 7,
   parameter int COL_BITS      = 3,
   parameter int OUT_ROWS      = 100,
   parameter int FIFO_DEPTH    = 8,
   parameter int FIFO_PTR_BITS = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_valid,
   input  logic [DATA_BITS-1:0]         i_result_1,
   input  logic [DATA_BITS-1:0]         i_result_2,
   input  logic [ROW_BITS-1:0]          i_row_idx,
   input  logic [COL_BITS-1:0]          i_col_idx_1,
   input  logic [COL_BITS-1:0]          i_col_idx_2,
   input  logic                         i_clear,
   input  logic                         i_mem_ready,
   output logic                         o_mem_wen,
   output logic [ROW_BITS+COL_BITS-1:0] o_mem_addr,
   output logic [DATA_BITS-1:0]         o_mem_data,
   output logic [FIFO_PTR_BITS:0]       o_fifo_cnt,
   output logic                         o_overflow,
   output logic                         o_range_err,
   output logic                         o_done
);

   localparam int OUT_COLS   = 1 << COL_BITS;
   localparam int TOTAL      = OUT_ROWS * OUT_COLS;
   localparam int WCNT_BITS  = $clog2(TOTAL + 1);
   localparam int ADDR_BITS  = ROW_BITS + COL_BITS;
   localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;
   localparam int CNT_BITS   = FIFO_PTR_BITS + 1;

   // A pair fits only if at least two slots are free before any pop.
   localparam logic [CNT_BITS-1:0]  PUSH_LIMIT = CNT_BITS'(FIFO_DEPTH - 2);
   // One extra bit so OUT_ROWS == 2^ROW_BITS is still representable.
   localparam logic [ROW_BITS:0]    ROW_LIMIT  = (ROW_BITS + 1)'(OUT_ROWS);
   localparam logic [WCNT_BITS-1:0] WCNT_MAX   = WCNT_BITS'(TOTAL);

   logic                     valid_prev_q;
   logic [FIFO_PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_PTR_BITS-1:0] wr_ptr_nxt1;
   logic [CNT_BITS-1:0]      cnt_q, cnt_d;
   logic [WCNT_BITS-1:0]     wcnt_q, wcnt_d;
   logic                     done_q, ovf_q, rerr_q;
   logic [ENTRY_BITS-1:0]    mem_q [FIFO_DEPTH];
   logic [ENTRY_BITS-1:0]    head;
   logic [ENTRY_BITS-1:0]    entry_1, entry_2;

   logic capture, row_bad, room, push, pop, ovf_evt, rerr_evt;

   assign capture  = i_valid & ~valid_prev_q;
   assign row_bad  = ({1'b0, i_row_idx} >= ROW_LIMIT);
   assign room     = (cnt_q <= PUSH_LIMIT);
   assign push     = capture & ~row_bad & room & ~i_clear;
   assign ovf_evt  = capture & ~row_bad & ~room;
   assign rerr_evt = capture & row_bad;
   assign pop      = o_mem_wen & i_mem_ready;

   assign entry_1     = {i_row_idx, i_col_idx_1, i_result_1};
   assign entry_2     = {i_row_idx, i_col_idx_2, i_result_2};
   assign wr_ptr_nxt1 = wr_ptr_q + FIFO_PTR_BITS'(1);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      wcnt_d   = wcnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + FIFO_PTR_BITS'(2);
         cnt_d    = cnt_d + CNT_BITS'(2);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + FIFO_PTR_BITS'(1);
         cnt_d    = cnt_d - CNT_BITS'(1);
         // Saturate so extra writes after completion cannot wrap the count.
         if (wcnt_q != WCNT_MAX) begin
            wcnt_d = wcnt_q + WCNT_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_prev_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         wcnt_q       <= '0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
         rerr_q       <= 1'b0;
      end else begin
         // Edge detector keeps tracking the level even through a clear.
         valid_prev_q <= i_valid;
         if (i_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rerr_q   <= 1'b0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            // Completion is flagged the cycle after the count reaches its end.
            done_q   <= done_q | (wcnt_q == WCNT_MAX);
            if (ovf_evt) begin
               ovf_q <= 1'b1;
            end
            if (rerr_evt) begin
               rerr_q <= 1'b1;
            end
         end
      end
   end

   // Queue storage: each slot loads result 1 when it is the write pointer
   // and result 2 when it is the slot after it. Contents need no reset since
   // the outputs are qualified by a non-empty queue.
   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == FIFO_PTR_BITS'(gi))) begin
               mem_q[gi] <= entry_1;
            end else if (push && (wr_ptr_nxt1 == FIFO_PTR_BITS'(gi))) begin
               mem_q[gi] <= entry_2;
            end
         end
      end
   endgenerate

   assign head = mem_q[rd_ptr_q];

   // Occupancy is a register cleared asynchronously, so the write request
   // and the presented address/data collapse the moment rst rises.
   assign o_mem_wen   = (cnt_q != '0);
   assign o_mem_addr  = o_mem_wen ? head[ENTRY_BITS-1:DATA_BITS] : '0;
   assign o_mem_data  = o_mem_wen ? head[DATA_BITS-1:0] : '0;
   assign o_fifo_cnt  = cnt_q;
   assign o_overflow  = ovf_q;
   assign o_range_err = rerr_q;
   assign o_done      = done_q;

endmodule

// File: tb/tb_result_writeback.sv
module tb_result_writeback;

   logic        clk;
   logic        rst;
   logic        i_valid;
   logic [15:0] i_result_1;
   logic [15:0] i_result_2;
   logic [6:0]  i_row_idx;
   logic [2:0]  i_col_idx_1;
   logic [2:0]  i_col_idx_2;
   logic        i_clear;
   logic        i_mem_ready;
   logic        o_mem_wen;
   logic [9:0]  o_mem_addr;
   logic [15:0] o_mem_data;
   logic [3:0]  o_fifo_cnt;
   logic        o_overflow;
   logic        o_range_err;
   logic        o_done;

   result_writeback dut (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (i_valid),
      .i_result_1 (i_result_1),
      .i_result_2 (i_result_2),
      .i_row_idx  (i_row_idx),
      .i_col_idx_1(i_col_idx_1),
      .i_col_idx_2(i_col_idx_2),
      .i_clear    (i_clear),
      .i_mem_ready(i_mem_ready),
      .o_mem_wen  (o_mem_wen),
      .o_mem_addr (o_mem_addr),
      .o_mem_data (o_mem_data),
      .o_fifo_cnt (o_fifo_cnt),
      .o_overflow (o_overflow),
      .o_range_err(o_range_err),
      .o_done     (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total;
   int          bad;
   int          writes_seen;
   int          stream_writes;
   int          distinct;
   int          done_cd;
   bit          stream_on;
   bit          seen [1024];
   logic [25:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every accepted write is compared to the queue head.
   task automatic monitor();
      logic [25:0] e;
      forever begin
         @(negedge clk);
         if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) check("done_after_800", {31'b0, o_done}, 32'd1);
         end
         if (!rst && o_mem_wen && i_mem_ready) begin
            writes_seen++;
            $display("wr addr=%h data=%h", o_mem_addr, o_mem_data);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got addr=%h data=%h required none",
                        o_mem_addr, o_mem_data);
            end else begin
               e = exp_q.pop_front();
               check("write", {6'b0, o_mem_addr, o_mem_data}, {6'b0, e});
            end
            if (stream_on) begin
               stream_writes++;
               if (!seen[o_mem_addr]) begin
                  seen[o_mem_addr] = 1'b1;
                  distinct++;
               end
               if (stream_writes == 800) begin
                  check("done_before_800th", {31'b0, o_done}, 32'd0);
                  done_cd = 2;
               end
            end
         end
      end
   endtask

   // One capture pulse: valid high for one cycle, then low for one cycle.
   task automatic capture(input logic [6:0] row, input logic [2:0] c1, input logic [15:0] r1,
                          input logic [2:0] c2, input logic [15:0] r2, input bit exp_push);
      @(posedge clk); #1;
      i_valid     = 1'b1;
      i_row_idx   = row;
      i_col_idx_1 = c1;
      i_col_idx_2 = c2;
      i_result_1  = r1;
      i_result_2  = r2;
      if (exp_push) begin
         exp_q.push_back({row, c1, r1});
         exp_q.push_back({row, c2, r2});
      end
      $display("cap row=%0d c1=%0d r1=%h c2=%0d r2=%h", row, c1, r1, c2, r2);
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      @(negedge clk);
      check(name, exp_q.size(), 32'd0);
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1;
      i_clear = 1'b1;
      @(posedge clk); #1;
      i_clear = 1'b0;
   endtask

   initial begin
      int          base;
      logic [6:0]  rr;
      logic [2:0]  ca, cb;
      total = 0; bad = 0; writes_seen = 0; stream_writes = 0; distinct = 0;
      done_cd = 0; stream_on = 1'b0;
      rst = 1'b1; i_valid = 1'b0; i_result_1 = '0; i_result_2 = '0;
      i_row_idx = '0; i_col_idx_1 = '0; i_col_idx_2 = '0;
      i_clear = 1'b0; i_mem_ready = 1'b1;
      fork
         monitor();
      join_none

      // Reset state
      #2;
      check("rst_wen",  {31'b0, o_mem_wen}, 32'd0);
      check("rst_addr", {22'b0, o_mem_addr}, 32'd0);
      check("rst_data", {16'b0, o_mem_data}, 32'd0);
      check("rst_cnt",  {28'b0, o_fifo_cnt}, 32'd0);
      check("rst_flags", {29'b0, o_overflow, o_range_err, o_done}, 32'd0);
      @(negedge clk); #2;
      rst = 1'b0;

      // Held level gives one capture; first write one cycle after capture
      base = writes_seen;
      @(posedge clk); #1;
      i_valid = 1'b1; i_row_idx = 7'd3; i_col_idx_1 = 3'd0; i_col_idx_2 = 3'd1;
      i_result_1 = 16'h0011; i_result_2 = 16'h0022;
      exp_q.push_back({7'd3, 3'd0, 16'h0011});
      exp_q.push_back({7'd3, 3'd1, 16'h0022});
      @(negedge clk);
      check("lat_before", {31'b0, o_mem_wen}, 32'd0);
      @(negedge clk);
      check("lat_wen",  {31'b0, o_mem_wen}, 32'd1);
      check("lat_addr", {22'b0, o_mem_addr}, 32'h018);
      check("lat_data", {16'b0, o_mem_data}, 32'h0011);
      repeat (3) @(posedge clk);
      #1 i_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("held_two_writes", writes_seen - base, 32'd2);
      check("held_queue_empty", exp_q.size(), 32'd0);

      // Back-pressure: four pairs fill the queue while ready is low
      @(posedge clk); #1 i_mem_ready = 1'b0;
      capture(7'd10, 3'd0, 16'h1000, 3'd1, 16'h1001, 1'b1);
      capture(7'd11, 3'd2, 16'h1002, 3'd3, 16'h1003, 1'b1);
      capture(7'd12, 3'd4, 16'h1004, 3'd5, 16'h1005, 1'b1);
      capture(7'd13, 3'd6, 16'h1006, 3'd7, 16'h1007, 1'b1);
      @(negedge clk);
      check("full_cnt",  {28'b0, o_fifo_cnt}, 32'd8);
      check("full_head", {6'b0, o_mem_addr, o_mem_data}, {6'b0, 10'h050, 16'h1000});
      check("full_no_ovf", {31'b0, o_overflow}, 32'd0);
      // One pop leaves seven entries; a further pair must not fit
      @(posedge clk); #1 i_mem_ready = 1'b1;
      @(posedge clk); #1 i_mem_ready = 1'b0;
      @(negedge clk);
      check("seven_cnt", {28'b0, o_fifo_cnt}, 32'd7);
      capture(7'd20, 3'd0, 16'hDEAD, 3'd1, 16'hBEEF, 1'b0);
      @(negedge clk);
      check("ovf_flag", {31'b0, o_overflow}, 32'd1);
      check("ovf_cnt",  {28'b0, o_fifo_cnt}, 32'd7);
      repeat (3) @(negedge clk);
      check("held_head", {6'b0, o_mem_addr, o_mem_data}, {6'b0, 10'h051, 16'h1001});
      @(posedge clk); #1 i_mem_ready = 1'b1;
      wait_drain("bp_drain");

      // Clear flags, then an out-of-range row
      pulse_clear();
      @(negedge clk);
      check("clr_ovf", {31'b0, o_overflow}, 32'd0);
      base = writes_seen;
      capture(7'd100, 3'd0, 16'h5555, 3'd1, 16'h6666, 1'b0);
      @(negedge clk);
      check("range_err", {31'b0, o_range_err}, 32'd1);
      check("range_no_ovf", {31'b0, o_overflow}, 32'd0);
      check("range_cnt", {28'b0, o_fifo_cnt}, 32'd0);
      repeat (3) @(negedge clk);
      check("range_no_write", writes_seen - base, 32'd0);
      pulse_clear();

      // Full matrix stream
      stream_on = 1'b1;
      for (int r = 0; r < 100; r++) begin
         for (int p = 0; p < 4; p++) begin
            rr = 7'(r);
            ca = 3'(2 * p);
            cb = 3'(2 * p + 1);
            capture(rr, ca, {6'b101010, rr, ca}, cb, {6'b101010, rr, cb}, 1'b1);
         end
      end
      wait_drain("stream_drain");
      repeat (3) @(negedge clk);
      stream_on = 1'b0;
      check("stream_writes", stream_writes, 32'd800);
      check("stream_distinct", distinct, 32'd800);
      check("stream_done", {31'b0, o_done}, 32'd1);

      // Clear with three queued entries and done set; a same-cycle capture is lost
      @(posedge clk); #1 i_mem_ready = 1'b0;
      capture(7'd1, 3'd0, 16'h0A00, 3'd1, 16'h0A01, 1'b1);
      capture(7'd2, 3'd2, 16'h0B02, 3'd3, 16'h0B03, 1'b1);
      @(posedge clk); #1 i_mem_ready = 1'b1;
      @(posedge clk); #1 i_mem_ready = 1'b0;
      capture(7'd120, 3'd0, 16'h0C00, 3'd1, 16'h0C01, 1'b0);
      @(negedge clk);
      check("pre_clr_cnt",  {28'b0, o_fifo_cnt}, 32'd3);
      check("pre_clr_done", {31'b0, o_done}, 32'd1);
      check("pre_clr_rerr", {31'b0, o_range_err}, 32'd1);
      @(posedge clk); #1;
      i_clear = 1'b1; i_valid = 1'b1; i_row_idx = 7'd5;
      exp_q.delete();
      @(posedge clk); #1;
      i_clear = 1'b0; i_valid = 1'b0;
      @(negedge clk);
      check("clr_wen",  {31'b0, o_mem_wen}, 32'd0);
      check("clr_cnt",  {28'b0, o_fifo_cnt}, 32'd0);
      check("clr_flags", {29'b0, o_overflow, o_range_err, o_done}, 32'd0);

      // Asynchronous reset while a write is pending
      capture(7'd7, 3'd2, 16'h7777, 3'd3, 16'h8888, 1'b1);
      @(negedge clk);
      check("arst_pre_wen", {31'b0, o_mem_wen}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_wen", {31'b0, o_mem_wen}, 32'd0);
      check("arst_cnt", {28'b0, o_fifo_cnt}, 32'd0);
      exp_q.delete();
      @(negedge clk); #2 rst = 1'b0;
      base = writes_seen;
      @(posedge clk); #1 i_mem_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("arst_no_write", writes_seen - base, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
